// File: rtl/multi_word_adder.sv
// rtl/multi_word_adder.sv - Sequential multi-word adder, one 16-bit slice per clock through a shared 16-bit CLA.
module multi_word_adder #(
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [16*NWORDS-1:0] A,
    input  logic [16*NWORDS-1:0] B,
    input  logic                 Cin,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [16*NWORDS-1:0] Sum,
    output logic                 Cout,
    output logic                 Ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int W  = 16 * NWORDS;
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic          ovf_reg;

    logic [15:0]   slice_a;
    logic [15:0]   slice_b;
    logic [15:0]   slice_sum;
    logic          slice_cout;

    // Operands are read from the latched copies so the inputs may change during RUN.
    assign slice_a = a_reg[16*idx +: 16];
    assign slice_b = b_reg[16*idx +: 16];

    CLA_16bit u_cla (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_reg),
        .Sum  (slice_sum),
        .Cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        carry_reg <= Cin;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[16*idx +: 16] <= slice_sum;
                    carry_reg             <= slice_cout;
                    idx                   <= idx + 1'b1;
                    if (idx == LAST) begin
                        // The top slice's sum MSB is the result sign bit.
                        ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[15] != a_reg[W-1]);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Sum       = sum_reg;
    assign Cout      = carry_reg;
    assign Ovf       = ovf_reg;
endmodule

// Two-level carry-lookahead adder: four 4-bit groups with a lookahead unit across groups.
module CLA_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    function automatic logic [3:0] grp_carries(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
        logic [3:0] r;
        r[0] = ci;
        r[1] = gi[0] | (pi[0] & ci);
        r[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        r[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
        return r;
    endfunction

    assign p = A ^ B;
    assign g = A & B;

    always_comb begin
        gp = '0;
        gg = '0;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Group carries are fully expanded so no carry waits on the group below it.
    always_comb begin
        gc    = '0;
        gc[0] = Cin;
        gc[1] = gg[0] | (gp[0] & Cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & Cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k +: 4] = grp_carries(g[4*k +: 4], p[4*k +: 4], gc[k]);
        end
    end

    assign Sum  = p ^ c;
    assign Cout = gc[4];
endmodule

// File: tb/tb_multi_word_adder.sv
// tb/tb_multi_word_adder.sv - Randomized self-checking bench for multi_word_adder against a behavioural model.
module tb_multi_word_adder;
    localparam int NWORDS = 4;
    localparam int W      = 16 * NWORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    multi_word_adder #(.NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: at most one operation outstanding; edges counts clocks since accept.
    logic         pending = 1'b0;
    int           edges   = 0;
    logic [W-1:0] cur_a, cur_b, last_sum, exp_sum;
    logic         cur_cin;
    logic [W:0]   full;

    initial begin
        last_sum = '0;
        cur_a = '0; cur_b = '0; cur_cin = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending  = 1'b0;
                last_sum = '0;
                check("rst_sum", Sum, 0);
                check("rst_cout", Cout, 0);
                check("rst_ovf", Ovf, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 1);
            end else begin
                if (pending) edges++;
                full    = {1'b0, cur_a} + {1'b0, cur_b} + {{W{1'b0}}, cur_cin};
                exp_sum = last_sum;
                if (pending) begin
                    for (int j = 0; j < NWORDS; j++) begin
                        if (j < edges) exp_sum[16*j +: 16] = full[16*j +: 16];
                    end
                end
                check("sum", Sum, exp_sum);
                check("in_ready", in_ready, !pending);
                check("out_valid", out_valid, pending && edges >= NWORDS);
                if (pending && edges >= NWORDS) begin
                    check("cout", Cout, full[W]);
                    check("ovf", Ovf, (cur_a[W-1] == cur_b[W-1]) && (full[W-1] != cur_a[W-1]));
                    if (out_ready) begin
                        pending  = 1'b0;
                        last_sum = full[W-1:0];
                    end
                end else if (!pending && in_valid) begin
                    pending = 1'b1;
                    edges   = -1;
                    cur_a   = A;
                    cur_b   = B;
                    cur_cin = Cin;
                end
            end
        end
    end

    task automatic scramble(input logic with_ready);
        A        = {$urandom, $urandom};
        B        = {$urandom, $urandom};
        Cin      = 1'($urandom);
        in_valid = 1'($urandom);
        if (with_ready) out_ready = 1'($urandom);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int stall,
                         input logic lit, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("accept_wait", n < 20, 1);
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 20) begin
            scramble(1'b1);
            @(posedge clk); #1; n++;
        end
        out_ready = 1'b0;
        check("latency", n, NWORDS);
        if (lit) begin
            check("lit_sum", Sum, es);
            check("lit_cout", Cout, ec);
            check("lit_ovf", Ovf, eo);
        end
        for (int s = 0; s < stall; s++) begin
            scramble(1'b0);
            @(posedge clk); #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            if (lit) check("stall_sum", Sum, es);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(64'h0000_0000_0000_1234, 64'h0000_0000_0000_5678, 1'b0, 0, 1'b1, 64'h0000_0000_0000_68AC, 1'b0, 1'b0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1, 1'b1, 64'h0, 1'b1, 1'b0);
        do_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 0, 1'b1, 64'h0, 1'b1, 1'b0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 5, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 1'b1, 64'h0, 1'b1, 1'b1);

        // Reset two clocks into an operation; the partial result must vanish.
        A = 64'h1111_2222_3333_4444; B = 64'h5555_6666_7777_8888; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_sum", Sum, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(64'd3, 64'd4, 1'b0, 0, 1'b1, 64'd7, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) rb = ~ra;
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            do_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'b0, '0, 1'b0, 1'b0);
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multi_word_adder.md
MULTI_WORD_ADDER -- requirements
Module: multi_word_adder

Interface
REQ-001 SHALL have parameter NWORDS, default 4, meaning the number of 16-bit slices per operand; legal values are 2..8.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port A, input, 16*NWORDS bits: operand A.
REQ-005 SHALL have port B, input, 16*NWORDS bits: operand B.
REQ-006 SHALL have port Cin, input, 1 bit: carry into slice 0.
REQ-007 SHALL have port in_valid, input, 1 bit: A, B and Cin are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-009 SHALL have port Sum, output, 16*NWORDS bits: registered result.
REQ-010 SHALL have port Cout, output, 1 bit: carry out of the top slice.
REQ-011 SHALL have port Ovf, output, 1 bit: signed two's-complement overflow.
REQ-012 SHALL have port out_valid, output, 1 bit: Sum, Cout and Ovf are valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-014 SHALL compute {Cout,Sum} = A + B + Cin modulo 2^(16*NWORDS+1), one 16-bit slice per clock.
- LSB slice first.
- Uses a single CLA_16bit instance (ports A, B, Cin, Sum, Cout).
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE; both are decoded from registered state.
REQ-017 On a rising edge with in_valid & in_ready, the block SHALL:
- latch A, B and Cin into internal registers;
- clear slice index idx to 0;
- go to RUN.
REQ-018 On each RUN edge, the block SHALL:
- feed slice idx of latched A and B, plus carry_reg, to the adder;
- write the adder Sum into Sum[16*idx +: 16];
- set carry_reg to the adder Cout;
- increment idx.
REQ-019 When idx = NWORDS-1 at a RUN edge, the block SHALL perform the REQ-018 update, then go to DONE.
REQ-020 Latency SHALL be exactly NWORDS clocks from the accept edge to out_valid=1 (4 clocks for the default).
REQ-021 In DONE, outputs SHALL be as follows:
- Cout = carry_reg;
- Ovf = (A_msb == B_msb) & (Sum_msb != A_msb), using the latched operands.
REQ-022 Sum, Cout and Ovf SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-023 On a rising edge with out_valid & out_ready, the block SHALL return to IDLE.
- in_ready rises the next cycle, so there is one bubble cycle between operations.
REQ-024 in_valid SHALL be ignored outside IDLE; A, B and Cin changing during RUN SHALL NOT affect the result.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 Carry SHALL propagate through all slices.
- Example: all-ones + 1 ripples through every slice, giving Sum=0 and Cout=1.
REQ-027 Sum SHALL retain its last value after leaving DONE until overwritten slice-by-slice by the next operation.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force the following, at any time including mid-RUN or in DONE:
- state=IDLE, idx=0, carry_reg=0;
- Sum=0, Cout=0, Ovf=0;
- out_valid=0, in_ready=1.
REQ-029 An operation interrupted by reset SHALL be discarded and never presented.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Basic add, NWORDS=4: A=0x0000_0000_0000_1234, B=0x0000_0000_0000_5678, Cin=0, out_ready=1.
- out_valid rises 4 clocks after accept.
- Response: Sum=0x0000_0000_0000_68AC, Cout=0, Ovf=0.
REQ-032 Full ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x0000_0000_0000_0001, Cin=0.
- Response: Sum=0, Cout=1, Ovf=0.
REQ-033 Alternating patterns with carry-in: A=0xAAAA_AAAA_AAAA_AAAA, B=0x5555_5555_5555_5555, Cin=1.
- Response: Sum=0, Cout=1.
- Second stimulus: A=B=0xFFFF_FFFF_FFFF_FFFF, Cin=1.
- Response: Sum=0xFFFF_FFFF_FFFF_FFFF, Cout=1, Ovf=0.
REQ-034 Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, Cin=0.
- Response: Sum=0x8000_0000_0000_0000, Ovf=1, Cout=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling A, B and in_valid meanwhile.
- Sum is unchanged and in_ready stays 0 during the stall.
- out_ready=1 returns the block to IDLE after 1 edge.
REQ-036 Reset mid-operation: assert rst_n=0 two clocks after an accept.
- All outputs are 0 at once and in_ready=1.
- After release, a new operation with A=3, B=4 yields Sum=7 with exact 4-clock latency.
